// File: rtl/matvec_engine.sv
// Y = A*X or Y = A^T*X over signed fixed point in a shared single-port memory.
// Define MATVEC_SAT_EN to saturate results instead of truncating them.
module matvec_engine #(
   parameter int W     = 16,
   parameter int AW    = 10,
   parameter int TW    = 4,
   parameter int ACC_W = 40
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic          mode,
   input  logic [W-1:0]  ROWS,
   input  logic [W-1:0]  COLS,
   input  logic [W-1:0]  STRIDE,
   input  logic [AW-1:0] A,
   input  logic [AW-1:0] X,
   input  logic [AW-1:0] Y,
   input  logic [TW-1:0] FRAC_SH,
   output logic          busy,
   output logic          done,
   output logic          mem_req,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [W-1:0]  mem_wdata,
   input  logic          mem_bsy,
   input  logic [W-1:0]  mem_rdata
);

   typedef enum logic [2:0] {
      IDLE, OUT_INIT, RD_A, RD_X, MAC, WR, DONE
   } state_t;

   localparam logic signed [ACC_W-1:0] SMAX =
      {{(ACC_W-W+1){1'b0}}, {(W-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] SMIN =
      {{(ACC_W-W+1){1'b1}}, {(W-1){1'b0}}};

   state_t                   state;
   logic [W-1:0]             outer_q, inner_q;
   logic [W-1:0]             o_cnt, i_cnt;
   logic [AW-1:0]            a_ostep, a_istep;
   logic [AW-1:0]            a_base, a_ptr;
   logic [AW-1:0]            x_q, x_ptr, y_ptr;
   logic [TW-1:0]            frac_q;
   logic [W-1:0]             a_q;
   logic                     first;
   logic signed [ACC_W-1:0]  acc;
   logic signed [2*W-1:0]    prod;
   logic signed [ACC_W-1:0]  acc_nxt;

   assign prod    = $signed(a_q) * $signed(mem_rdata);
   assign acc_nxt = acc + ACC_W'(prod);

   function automatic logic [W-1:0] shape(
      input logic signed [ACC_W-1:0] v,
      input logic [TW-1:0]           sh
   );
      logic signed [ACC_W-1:0] s;
      s = v >>> sh;
`ifdef MATVEC_SAT_EN
      if (s > SMAX) s = SMAX;
      else if (s < SMIN) s = SMIN;
`endif
      return s[W-1:0];
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         busy      <= 1'b0;
         done      <= 1'b0;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         outer_q   <= '0;
         inner_q   <= '0;
         o_cnt     <= '0;
         i_cnt     <= '0;
         a_ostep   <= '0;
         a_istep   <= '0;
         a_base    <= '0;
         a_ptr     <= '0;
         x_q       <= '0;
         x_ptr     <= '0;
         y_ptr     <= '0;
         frac_q    <= '0;
         a_q       <= '0;
         first     <= 1'b0;
         acc       <= '0;
      end else begin
         unique case (state)
            IDLE: if (start) begin
               // transpose just swaps loop bounds and the A walk direction
               outer_q <= mode ? COLS : ROWS;
               inner_q <= mode ? ROWS : COLS;
               a_ostep <= mode ? AW'(1) : AW'(STRIDE);
               a_istep <= mode ? AW'(STRIDE) : AW'(1);
               a_base  <= A;
               x_q     <= X;
               y_ptr   <= Y;
               frac_q  <= FRAC_SH;
               o_cnt   <= '0;
               busy    <= 1'b1;
               state   <= OUT_INIT;
            end
            OUT_INIT: begin
               acc   <= '0;
               i_cnt <= '0;
               a_ptr <= a_base;
               x_ptr <= x_q;
               if (outer_q == '0) begin
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= DONE;
               end else if (inner_q == '0) begin
                  mem_req   <= 1'b1;
                  mem_we    <= 1'b1;
                  mem_addr  <= y_ptr;
                  mem_wdata <= '0;
                  state     <= WR;
               end else begin
                  mem_req  <= 1'b1;
                  mem_we   <= 1'b0;
                  mem_addr <= a_base;
                  state    <= RD_A;
               end
            end
            RD_A: if (!mem_bsy) begin
               mem_addr <= x_ptr;
               a_ptr    <= a_ptr + a_istep;
               first    <= 1'b1;
               state    <= RD_X;
            end
            RD_X: begin
               // A word is only on mem_rdata in the first RD_X cycle
               if (first) begin
                  a_q   <= mem_rdata;
                  first <= 1'b0;
               end
               if (!mem_bsy) begin
                  mem_req <= 1'b0;
                  x_ptr   <= x_ptr + AW'(1);
                  state   <= MAC;
               end
            end
            MAC: begin
               acc   <= acc_nxt;
               i_cnt <= i_cnt + 1'b1;
               mem_req <= 1'b1;
               if (i_cnt + 1'b1 == inner_q) begin
                  mem_we    <= 1'b1;
                  mem_addr  <= y_ptr;
                  mem_wdata <= shape(acc_nxt, frac_q);
                  state     <= WR;
               end else begin
                  mem_we   <= 1'b0;
                  mem_addr <= a_ptr;
                  state    <= RD_A;
               end
            end
            WR: if (!mem_bsy) begin
               mem_req <= 1'b0;
               mem_we  <= 1'b0;
               y_ptr   <= y_ptr + AW'(1);
               a_base  <= a_base + a_ostep;
               o_cnt   <= o_cnt + 1'b1;
               if (o_cnt + 1'b1 == outer_q) begin
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= DONE;
               end else begin
                  state <= OUT_INIT;
               end
            end
            DONE: begin
               done  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_matvec_engine.sv
// Randomised bench for matvec_engine against a loop-level reference model.
// Memory, stall generator and request-stability monitor live here.
module tb_matvec_engine;
   localparam int W  = 16;
   localparam int AW = 10;
   localparam int TW = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic          mode = 1'b0;
   logic [W-1:0]  ROWS = '0, COLS = '0, STRIDE = '0;
   logic [AW-1:0] A = '0, X = '0, Y = '0;
   logic [TW-1:0] FRAC_SH = '0;
   logic          busy, done, mem_req, mem_we;
   logic [AW-1:0] mem_addr;
   logic [W-1:0]  mem_wdata;
   logic          mem_bsy = 1'b0;
   logic [W-1:0]  mem_rdata = '0;

   matvec_engine #(.W(W), .AW(AW), .TW(TW), .ACC_W(40)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .mode(mode),
      .ROWS(ROWS), .COLS(COLS), .STRIDE(STRIDE),
      .A(A), .X(X), .Y(Y), .FRAC_SH(FRAC_SH),
      .busy(busy), .done(done),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_bsy(mem_bsy), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   logic [W-1:0] mem [1024];
   logic [W-1:0] img [1024];
   logic         load = 1'b0;
   int           wr_cnt = 0;
   int           viol = 0;
   int           bsy_mode = 0;
   int           phase = 0;
   int           total = 0;
   int           bad = 0;

   always @(posedge clk) begin
      if (load) mem <= img;
      else if (mem_req && !mem_bsy && mem_we) begin
         mem[mem_addr] <= mem_wdata;
         wr_cnt <= wr_cnt + 1;
      end
      if (mem_req && !mem_bsy && !mem_we) mem_rdata <= mem[mem_addr];
      else mem_rdata <= W'($urandom);
   end

   logic          p_stall = 1'b0;
   logic          p_we = 1'b0;
   logic [AW-1:0] p_addr = '0;
   logic [W-1:0]  p_wd = '0;
   always @(posedge clk) begin
      if (rst_n && p_stall &&
          (!mem_req || mem_addr !== p_addr || mem_we !== p_we ||
           (p_we && mem_wdata !== p_wd)))
         viol <= viol + 1;
      p_stall <= rst_n && mem_req && mem_bsy;
      p_we    <= mem_we;
      p_addr  <= mem_addr;
      p_wd    <= mem_wdata;
   end

   always @(negedge clk) begin
      phase <= (phase == 11) ? 0 : phase + 1;
      case (bsy_mode)
         0:       mem_bsy <= 1'b0;
         1:       mem_bsy <= (phase >= 10);
         default: mem_bsy <= ($urandom_range(0, 2) == 0);
      endcase
   end

   logic [W-1:0] exp_v[$];
   int           exp_a[$];
   int           exp_busy;

   function automatic void model(input bit md, input int rows, input int cols,
                                 input int stride, input int a, input int x,
                                 input int y, input int sh);
      int outer, inner, ai, xi;
      longint acc, s;
      exp_v.delete();
      exp_a.delete();
      outer = md ? cols : rows;
      inner = md ? rows : cols;
      exp_busy = (outer == 0) ? 1 : outer * (2 + 3 * inner);
      for (int o = 0; o < outer; o++) begin
         acc = 0;
         for (int i = 0; i < inner; i++) begin
            ai = md ? (a + i * stride + o) : (a + o * stride + i);
            ai = ai & 1023;
            xi = (x + i) & 1023;
            acc += longint'($signed(img[ai])) * longint'($signed(img[xi]));
         end
         s = acc >>> sh;
`ifdef MATVEC_SAT_EN
         if (s > 32767) s = 32767;
         else if (s < -32768) s = -32768;
`endif
         exp_v.push_back(s[15:0]);
         exp_a.push_back((y + o) & 1023);
      end
   endfunction

   task automatic load_mem();
      @(negedge clk);
      load = 1'b1;
      @(negedge clk);
      load = 1'b0;
   endtask

   task automatic basic_image();
      for (int k = 0; k < 1024; k++) img[k] = W'($urandom);
      for (int k = 0; k < 25; k++) img[k] = W'(k / 5);
      for (int k = 0; k < 5; k++) img[32 + k] = W'(k + 1);
   endtask

   task automatic run_op(input bit md, input int rows, input int cols,
                         input int stride, input int a, input int x,
                         input int y, input int sh, input int repulse,
                         output int bcyc, output int dcnt, output bit tout);
      int seen;
      @(negedge clk);
      mode = md;
      ROWS = W'(rows);
      COLS = W'(cols);
      STRIDE = W'(stride);
      A = AW'(a);
      X = AW'(x);
      Y = AW'(y);
      FRAC_SH = TW'(sh);
      start = 1'b1;
      bcyc = 0;
      dcnt = 0;
      tout = 1'b1;
      seen = -1;
      for (int k = 0; k < 3000; k++) begin
         @(negedge clk);
         start = 1'b0;
         if (k == 0) begin
            ROWS = W'($urandom);
            COLS = W'($urandom);
            STRIDE = W'($urandom);
            A = AW'($urandom);
            X = AW'($urandom);
            Y = AW'($urandom);
            FRAC_SH = TW'($urandom);
         end
         if (k == repulse) begin
            start = 1'b1;
            mode = ~md;
         end
         if (busy) bcyc++;
         if (done) begin
            dcnt++;
            if (seen < 0) seen = k;
         end
         if (seen >= 0 && k == seen + 3) begin
            tout = 1'b0;
            break;
         end
      end
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      total++;
      if ({busy, done, mem_req, mem_we} !== 4'b0) begin
         bad++;
         $display("FAIL reset_ctl: got %b want 0000",
                  {busy, done, mem_req, mem_we});
      end
      total++;
      if (mem_addr !== '0 || mem_wdata !== '0) begin
         bad++;
         $display("FAIL reset_bus: got addr=%0h wdata=%0h want 0 0",
                  mem_addr, mem_wdata);
      end
      rst_n = 1'b1;
   endtask

   task automatic test_case(input string name, input bit md, input int rows,
                            input int cols, input int stride, input int a,
                            input int x, input int y, input int sh,
                            input int bmode, input int repulse,
                            input bit chk_busy);
      int b, d, w0, v0;
      bit t;
      bsy_mode = bmode;
      model(md, rows, cols, stride, a, x, y, sh);
      w0 = wr_cnt;
      v0 = viol;
      run_op(md, rows, cols, stride, a, x, y, sh, repulse, b, d, t);
      bsy_mode = 0;
      total++;
      if (t) begin
         bad++;
         $display("FAIL %s_timeout: no done within budget", name);
      end
      for (int j = 0; j < exp_v.size(); j++) begin
         total++;
         if (mem[exp_a[j]] !== exp_v[j]) begin
            bad++;
            $display("FAIL %s_y%0d: got %0h want %0h", name, j,
                     mem[exp_a[j]], exp_v[j]);
         end
      end
      total++;
      if (d !== 1) begin
         bad++;
         $display("FAIL %s_done: got %0d pulses want 1", name, d);
      end
      total++;
      if (wr_cnt - w0 !== exp_v.size()) begin
         bad++;
         $display("FAIL %s_writes: got %0d want %0d", name, wr_cnt - w0,
                  exp_v.size());
      end
      total++;
      if (viol !== v0) begin
         bad++;
         $display("FAIL %s_stall_stable: got %0d changes want 0", name,
                  viol - v0);
      end
      if (chk_busy) begin
         total++;
         if (b !== exp_busy) begin
            bad++;
            $display("FAIL %s_busy: got %0d want %0d", name, b, exp_busy);
         end
      end
   endtask

   task automatic test_normal();
      basic_image();
      load_mem();
      test_case("normal", 0, 5, 5, 5, 0, 32, 64, 0, 0, -1, 1);
      total++;
      if (mem[66] !== 16'd30 || mem[68] !== 16'd60) begin
         bad++;
         $display("FAIL normal_const: got %0d %0d want 30 60",
                  mem[66], mem[68]);
      end
   endtask

   task automatic test_transpose();
      basic_image();
      load_mem();
      test_case("transpose", 1, 5, 5, 5, 0, 32, 64, 0, 0, -1, 1);
      total++;
      if (mem[64] !== 16'd40) begin
         bad++;
         $display("FAIL transpose_const: got %0d want 40", mem[64]);
      end
   endtask

   task automatic test_stall();
      basic_image();
      load_mem();
      test_case("stall", 0, 5, 5, 5, 0, 32, 64, 0, 1, -1, 0);
      basic_image();
      load_mem();
      test_case("stall_rnd", 1, 5, 5, 5, 0, 32, 64, 0, 2, -1, 0);
   endtask

   task automatic test_degenerate();
      basic_image();
      load_mem();
      test_case("rows0", 0, 0, 5, 5, 0, 32, 64, 0, 0, -1, 1);
      basic_image();
      load_mem();
      test_case("cols0", 0, 3, 0, 5, 0, 32, 64, 0, 2, -1, 0);
   endtask

   task automatic test_overflow();
      logic [W-1:0] want;
      basic_image();
      img[0] = 16'h7FFF;
      img[1] = 16'h7FFF;
      img[32] = 16'h7FFF;
      img[33] = 16'h7FFF;
      load_mem();
      test_case("ovf", 0, 1, 2, 5, 0, 32, 64, 0, 0, -1, 1);
`ifdef MATVEC_SAT_EN
      want = 16'h7FFF;
`else
      want = 16'h0002;
`endif
      total++;
      if (mem[64] !== want) begin
         bad++;
         $display("FAIL ovf_const: got %0h want %0h", mem[64], want);
      end
      basic_image();
      load_mem();
      test_case("frac", 0, 5, 5, 5, 0, 32, 64, 4, 0, -1, 1);
   endtask

   task automatic test_back_to_back();
      for (int n = 0; n < 8; n++) begin
         int rows, cols, stride, a, sh;
         bit md;
         for (int k = 0; k < 1024; k++) img[k] = W'($urandom);
         md = 1'($urandom);
         rows = $urandom_range(0, 5);
         cols = $urandom_range(0, 5);
         stride = $urandom_range(5, 9);
         a = (n % 2 == 0) ? 100 : 1015;
         sh = $urandom_range(0, 3);
         load_mem();
         test_case("random", md, rows, cols, stride, a, 300, 400, sh,
                   (n % 3 == 0) ? 0 : 2, -1, (n % 3 == 0));
      end
   endtask

   task automatic test_restart();
      basic_image();
      load_mem();
      test_case("restart", 0, 5, 5, 5, 0, 32, 64, 0, 0, 10, 1);
   endtask

   task automatic test_reset_mid();
      int dseen;
      basic_image();
      load_mem();
      @(negedge clk);
      mode = 1'b0;
      ROWS = 16'd5;
      COLS = 16'd5;
      STRIDE = 16'd5;
      A = '0;
      X = 10'd32;
      Y = 10'd64;
      FRAC_SH = '0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (20) @(negedge clk);
      rst_n = 1'b0;
      #1;
      total++;
      if ({busy, done, mem_req, mem_we} !== 4'b0 ||
          mem_addr !== '0 || mem_wdata !== '0) begin
         bad++;
         $display("FAIL reset_mid: got ctl=%b addr=%0h want all zero",
                  {busy, done, mem_req, mem_we}, mem_addr);
      end
      dseen = 0;
      repeat (3) begin
         @(negedge clk);
         if (done || mem_req) dseen++;
      end
      total++;
      if (dseen !== 0) begin
         bad++;
         $display("FAIL reset_hold: got %0d active cycles want 0", dseen);
      end
      rst_n = 1'b1;
      basic_image();
      load_mem();
      test_case("after_reset", 0, 5, 5, 5, 0, 32, 64, 0, 0, -1, 1);
   endtask

   initial begin
      test_reset();
      test_normal();
      test_transpose();
      test_stall();
      test_degenerate();
      test_overflow();
      test_back_to_back();
      test_restart();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
